// File: rtl/instr_encoder.sv
// Two-stage immediate packer: merges a sign-extended immediate into an instruction template.
// Optional range checking (err / err_count) is enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr_out,
    output logic        err,
    output logic [7:0]  err_count
);

    localparam logic [2:0] FMT_I = 3'b000;
    localparam logic [2:0] FMT_S = 3'b001;
    localparam logic [2:0] FMT_B = 3'b010;
    localparam logic [2:0] FMT_U = 3'b011;
    localparam logic [2:0] FMT_J = 3'b100;

    logic        advance;
    logic        s1_valid;
    logic [2:0]  s1_src;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;

    // Both stages move together; a full S2 with a stalled consumer freezes everything.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    function automatic logic [31:0] pack(input logic [2:0] src, input logic [31:0] v,
                                         input logic [31:0] b);
        logic [31:0] w;
        w = b;
        case (src)
            FMT_I: w[31:20] = v[11:0];
            FMT_S: begin
                w[31:25] = v[11:5];
                w[11:7]  = v[4:0];
            end
            FMT_B: begin
                w[31]    = v[12];
                w[30:25] = v[10:5];
                w[11:8]  = v[4:1];
                w[7]     = v[11];
            end
            FMT_U: w[31:12] = v[31:12];
            FMT_J: begin
                w[31]    = v[20];
                w[30:21] = v[10:1];
                w[20]    = v[11];
                w[19:12] = v[19:12];
            end
            default: ;
        endcase
        return w;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_src    <= 3'b000;
            s1_imm    <= 32'h0000_0000;
            s1_base   <= 32'h0000_0000;
            out_valid <= 1'b0;
            instr_out <= 32'h0000_0000;
        end else if (advance) begin
            s1_valid  <= in_valid;
            if (in_valid) begin
                s1_src  <= imm_src;
                s1_imm  <= imm;
                s1_base <= base;
            end
            out_valid <= s1_valid;
            if (s1_valid) begin
                instr_out <= pack(s1_src, s1_imm, s1_base);
            end
        end
    end

`ifdef INSTR_ENC_RANGE_CHECK_EN
    logic s1_err;

    // Field must hold the value after truncation; branch/jump offsets must also be even.
    function automatic logic range_err(input logic [2:0] src, input logic [31:0] v);
        case (src)
            FMT_I, FMT_S: return !((&v[31:11]) || !(|v[31:11]));
            FMT_B:        return !((&v[31:12]) || !(|v[31:12])) || v[0];
            FMT_U:        return |v[11:0];
            FMT_J:        return !((&v[31:20]) || !(|v[31:20])) || v[0];
            default:      return 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_err    <= 1'b0;
            err       <= 1'b0;
            err_count <= 8'h00;
        end else begin
            if (advance) begin
                s1_err <= in_valid && range_err(imm_src, imm);
                err    <= s1_valid && s1_err;
            end
            if (out_valid && out_ready && err && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign err       = 1'b0;
    assign err_count = 8'h00;
`endif

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  request carries a valid encode job.
REQ-004 in_ready  output  1  encoder accepts the job this cycle.
REQ-005 imm_src  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, others invalid.
REQ-006 imm  input  32  sign-extended immediate value to be encoded.
REQ-007 base  input  32  instruction template carrying opcode, rd, rs1, rs2 and funct fields.
REQ-008 out_valid  output  1  instr_out holds a finished instruction.
REQ-009 out_ready  input  1  consumer takes instr_out this cycle.
REQ-010 instr_out  output  32  packed instruction.
REQ-011 err  output  1  immediate not representable in the selected format; qualified by out_valid.
REQ-012 err_count  output  8  saturating count of errored instructions delivered.

Function
REQ-013 The encoder SHALL be a two-stage pipeline: S1 registers the inputs and computes the range check; S2 registers the packed word and err.
REQ-014 A transfer SHALL occur on in_valid && in_ready, and on out_valid && out_ready.
REQ-015 The pipeline SHALL advance when (!out_valid || out_ready); in_ready SHALL equal that condition, and both stages SHALL hold while it is low.
REQ-016 Latency SHALL be 2 cycles from input transfer to out_valid, with throughput of one instruction per cycle while out_ready is high.
REQ-017 Every bit not covered by the format's immediate field SHALL be copied from base unchanged.
REQ-018 I format SHALL place instr[31:20]=imm[11:0].
REQ-019 S format SHALL place instr[31:25]=imm[11:5] and instr[11:7]=imm[4:0].
REQ-020 B format SHALL place instr[31]=imm[12], [7]=imm[11], [30:25]=imm[10:5] and [11:8]=imm[4:1].
REQ-021 U format SHALL place instr[31:12]=imm[31:12].
REQ-022 J format SHALL place instr[31]=imm[20], [19:12]=imm[19:12], [20]=imm[11] and [30:21]=imm[10:1].
REQ-023 An invalid imm_src SHALL output base unchanged.
REQ-024 err_count SHALL increment on each output transfer with err=1 and SHALL saturate at 255.
REQ-025 A simultaneous output transfer and input transfer SHALL move both stages in the same cycle, with no bubble and no loss.

Reset
REQ-026 While reset is high, out_valid, the S1 valid flag, err and err_count SHALL be 0, and instr_out SHALL be 0x00000000.
REQ-027 Reset mid-operation SHALL discard both in-flight jobs without delivering them, and in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 With INSTR_ENC_RANGE_CHECK_EN defined, err SHALL be set under the following rules:
- I or S: imm[31:11] not all equal.
- B: imm[31:12] not all equal, or imm[0]=1.
- U: imm[11:0]!=0.
- J: imm[31:20] not all equal, or imm[0]=1.
- Invalid imm_src: always.
In every case the bits SHALL still be packed per REQ-018..023.
REQ-029 Without INSTR_ENC_RANGE_CHECK_EN, err and err_count SHALL be constant 0, and packing SHALL be identical.

Verification
REQ-030 The bench SHALL cover an I-type encode: base=0x00000013, imm=5, imm_src=000 -> instr_out=0x00500013 two cycles later, err=0.
REQ-031 The bench SHALL cover B and S encodes:
- B: base=0x00000063, imm=0xFFFFFFFC, imm_src=010 -> 0xFE000EE3.
- S: base=0x00002023, imm=8, imm_src=001 -> 0x00002423.
REQ-032 The bench SHALL cover U and J encodes:
- U: base=0x000000B7, imm=0x12345000 -> 0x123450B7.
- J: base=0x0000006F, imm=8 -> 0x0080006F.
- Both with err=0.
REQ-033 The bench SHALL cover a range error with INSTR_ENC_RANGE_CHECK_EN defined: I-type imm=2048, base=0x00000013 -> instr_out=0x80000013, err=1, err_count=1.
REQ-034 The bench SHALL cover backpressure:
- Stimulus: three back-to-back jobs, out_ready held low for 4 cycles, then high.
- Required response: in_ready=0 while both stages are full and instr_out is stable.
- Required response: all three jobs delivered in order with no duplicates.
REQ-035 The bench SHALL cover reset mid-operation: assert reset with two jobs in flight -> out_valid=0 on the next edge, err_count=0, and neither job is ever delivered.
